// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl
// Interrupt controller sitting in front of a RISC-V core. Raw, asynchronous
// event lines are synchronised, classified as edge- or level-type, latched
// into PENDING, gated by MASK and presented to the core on irq_o. A small
// register port (two-state IDLE/RESP handshake) gives access to MASK,
// PENDING (W1C), SET (W1S) and EDGE.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset
//   event_i[31:0] raw interrupt sources (asynchronous to clk)
//   irq_o[31:0]   registered PENDING & MASK
//   save_cause_i  core accepted a trap this cycle
//   cause_i[5:0]  bit 5 = interrupt, bits 4:0 = line index
//   reg_req_i     register access request
//   reg_we_i      1 = write, 0 = read
//   reg_addr_i    byte address, bits 3:2 select the register
//   reg_wdata_i   write data
//   reg_rdata_o   read data, zero unless reg_ready_o is high
//   reg_ready_o   one-cycle completion strobe
module riscv_irq_ctrl #(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] event_i,
  output logic [31:0] irq_o,
  input  logic        save_cause_i,
  input  logic [5:0]  cause_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_ready_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_SET  = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][31:0] r_sync;
  logic [31:0] r_prev;
  logic [31:0] r_mask;
  logic [31:0] r_pending;
  logic [31:0] r_edge;
  logic [31:0] r_irq;
  logic [31:0] r_rdata;
  logic        r_ready;
  state_t      r_state;

  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_wr;
  logic [1:0]  w_sel;
  logic [31:0] w_sync;
  logic [31:0] w_rise;
  logic [31:0] w_ack;
  logic [31:0] w_w1c;
  logic [31:0] w_setw;
  logic [31:0] w_edge_arm;
  logic [31:0] w_rd_data;
  logic [31:0] w_edge_pend;
  logic [31:0] w_pending_nxt;
  logic        w_unused;

  // Byte-lane bits of the address carry no meaning.
  assign w_unused = ^reg_addr_i[1:0];

  assign w_sel  = reg_addr_i[3:2];
  assign w_wr   = w_accept & reg_we_i;
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;

  // Only interrupt causes acknowledge a line; exceptions leave PENDING alone.
  assign w_ack = (save_cause_i && cause_i[5]) ? (32'h0000_0001 << cause_i[4:0]) : 32'h0000_0000;

  // Synchroniser chain plus one extra flop used for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 32'h0000_0000;
    end else begin
      r_sync[0] <= event_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= w_sync;
    end
  end

  // Register decode: read mux (pre-write values) and write strobes.
  always_comb begin
    w_rd_data  = 32'h0000_0000;
    w_w1c      = 32'h0000_0000;
    w_setw     = 32'h0000_0000;
    w_edge_arm = 32'h0000_0000;
    case (w_sel)
      ADDR_MASK: w_rd_data = r_mask;
      ADDR_PEND: begin
        w_rd_data = r_pending;
        if (w_wr) w_w1c = reg_wdata_i;
      end
      ADDR_SET: begin
        if (w_wr) w_setw = reg_wdata_i;
      end
      ADDR_EDGE: begin
        w_rd_data = r_edge;
        // Lines switching level->edge must start with nothing pending.
        if (w_wr) w_edge_arm = reg_wdata_i & ~r_edge;
      end
      default: w_rd_data = 32'h0000_0000;
    endcase
  end

  // Set beats clear on edge lines; level lines simply mirror sync.
  assign w_edge_pend   = (r_pending & ~(w_ack | w_w1c)) | w_rise | w_setw;
  assign w_pending_nxt = ((r_edge & w_edge_pend) | (~r_edge & w_sync)) & ~w_edge_arm;

  // Control/status registers and the registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask    <= 32'h0000_0000;
      r_edge    <= 32'h0000_0000;
      r_pending <= 32'h0000_0000;
      r_irq     <= 32'h0000_0000;
    end else begin
      if (w_wr && (w_sel == ADDR_MASK)) r_mask <= reg_wdata_i;
      if (w_wr && (w_sel == ADDR_EDGE)) r_edge <= reg_wdata_i;
      r_pending <= w_pending_nxt;
      r_irq     <= r_pending & r_mask;
    end
  end

  // Access FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Access FSM next-state: accept in IDLE, spend exactly one cycle in RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (reg_req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response registers: ready/rdata are high only during the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_ready <= w_accept;
      r_rdata <= w_accept ? w_rd_data : 32'h0000_0000;
    end
  end

  assign irq_o       = r_irq;
  assign reg_ready_o = r_ready;
  assign reg_rdata_o = r_rdata;

endmodule
